// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus: raw switch levels in, debounced levels and edge pulses out.
interface sw_debounce_if #(
  parameter int unsigned WIDTH = 10
);
  logic [WIDTH-1:0] SW;
  logic [WIDTH-1:0] SW_clean;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output SW,
    input  SW_clean,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  SW,
    output SW_clean,
    output rise,
    output fall,
    output changed
  );
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus independent per-bit counter debounce for the slide-switch bus.
// Each bit's clean level follows its synchronized level only after STABLE_CYCLES of mismatch.
module sw_debounce #(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  sw_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Counter value is the per-bit state: zero with a match is idle, anything else is settling.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.SW;
      sync2_q   <= sync1_q;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.SW_clean = clean_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.changed  = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with STABLE_CYCLES=4: expected update events are queued at stimulus
// time and matched against every observed pulse cycle by a negedge monitor.
module tb_sw_debounce;

  localparam int Lat = 6;  // edges from SW change to clean update when STABLE_CYCLES=4

  typedef struct {
    int         cyc;
    logic [9:0] clean;
    logic [9:0] rise;
    logic [9:0] fall;
  } ev_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   errors;
  int   checks;
  ev_t  exp_q[$];
  ev_t  e;

  sw_debounce_if #(.WIDTH(10)) bus ();

  sw_debounce #(
    .WIDTH        (10),
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every pulse cycle must match the oldest expected event exactly.
  always @(negedge clk) begin
    if (resetn && (bus.changed !== 1'b0 || (bus.rise | bus.fall) !== 10'h0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d clean=%h rise=%h fall=%h changed=%b (none expected)",
                 cyc, bus.SW_clean, bus.rise, bus.fall, bus.changed);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc || bus.SW_clean !== e.clean || bus.rise !== e.rise ||
            bus.fall !== e.fall || bus.changed !== 1'b1) begin
          errors++;
          $display("FAIL event got cyc=%0d clean=%h rise=%h fall=%h chg=%b want cyc=%0d clean=%h rise=%h fall=%h chg=1",
                   cyc, bus.SW_clean, bus.rise, bus.fall, bus.changed,
                   e.cyc, e.clean, e.rise, e.fall);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [9:0] clean, input logic [9:0] rise, input logic [9:0] fall);
    ev_t ev;
    ev.cyc   = cyc + Lat;
    ev.clean = clean;
    ev.rise  = rise;
    ev.fall  = fall;
    exp_q.push_back(ev);
  endtask

  // Waits only; callers do their own comparison afterwards.
  task automatic wait_drain();
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick(1);
    tick(3);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.SW = 10'h3FF;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if ({bus.SW_clean, bus.rise, bus.fall, bus.changed} !== 31'h0) begin
        errors++;
        $display("FAIL reset_hold clean=%h rise=%h fall=%h changed=%b want all 0",
                 bus.SW_clean, bus.rise, bus.fall, bus.changed);
      end
    end
    resetn = 1'b1;
    push_ev(10'h3FF, 10'h3FF, 10'h000);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_release_missing pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    bus.SW = 10'h000;
    push_ev(10'h000, 10'h000, 10'h3FF);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL all_fall_missing pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clean_step();
    bus.SW = 10'h200;
    push_ev(10'h200, 10'h200, 10'h000);
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || bus.SW_clean !== 10'h200) begin
      errors++;
      $display("FAIL clean_step pending=%0d clean=%h want 0 pending clean=200",
               exp_q.size(), bus.SW_clean);
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    bus.SW[0] = 1'b1; tick(3);
    bus.SW[0] = 1'b0; tick(2);
    bus.SW[0] = 1'b1; tick(3);
    bus.SW[0] = 1'b0; tick(2);
    checks++;
    if (bus.SW_clean !== 10'h200) begin
      errors++;
      $display("FAIL bounce_during clean=%h want 200", bus.SW_clean);
    end
    bus.SW[0] = 1'b1;
    push_ev(10'h201, 10'h001, 10'h000);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_settle_missing pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    bus.SW[1] = 1'b1; tick(3);
    bus.SW[1] = 1'b0; tick(10);
    checks++;
    if (bus.SW_clean !== 10'h201 || bus.changed !== 1'b0) begin
      errors++;
      $display("FAIL short_glitch clean=%h changed=%b want clean=201 changed=0",
               bus.SW_clean, bus.changed);
    end
  endtask

  task automatic test_simultaneous();
    bus.SW = 10'h003;
    push_ev(10'h003, 10'h002, 10'h200);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simultaneous_missing pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_mid_reset();
    bus.SW = 10'h203;
    tick(4);
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.SW_clean, bus.rise, bus.fall, bus.changed} !== 31'h0) begin
      errors++;
      $display("FAIL mid_reset clean=%h rise=%h fall=%h changed=%b want all 0",
               bus.SW_clean, bus.rise, bus.fall, bus.changed);
    end
    tick(1);
    resetn = 1'b1;
    push_ev(10'h203, 10'h203, 10'h000);
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || bus.SW_clean !== 10'h203) begin
      errors++;
      $display("FAIL mid_reset_recover pending=%0d clean=%h want 0 pending clean=203",
               exp_q.size(), bus.SW_clean);
      exp_q.delete();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    bus.SW = '0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d want completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
